ram_byte_arbiter: RTL



---
 rtl/ram_byte_arbiter_if.sv | 46 ++++
 rtl/ram_byte_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ram_byte_arbiter_if.sv
// Bus bundle between two 32-bit word requesters, the byte arbiter and a byte-wide dual-port RAM.
interface ram_byte_arbiter_if #(
   parameter int unsigned aw = 10
);
   logic [aw-3:0] m0_adr;
   logic [31:0]   m0_dat;
   logic [3:0]    m0_sel;
   logic          m0_we;
   logic          m0_stb;
   logic          m0_ack;
   logic [31:0]   m0_rdt;

   logic [aw-3:0] m1_adr;
   logic [31:0]   m1_dat;
   logic [3:0]    m1_sel;
   logic          m1_we;
   logic          m1_stb;
   logic          m1_ack;
   logic [31:0]   m1_rdt;

   logic          ram_wen;
   logic [aw-1:0] ram_waddr;
   logic [7:0]    ram_din;
   logic [aw-1:0] ram_raddr;
   logic [7:0]    ram_dout;

   // Arbiter side: requests and RAM read data in, acks/read data and RAM controls out.
   modport slave (
      input  m0_adr, m0_dat, m0_sel, m0_we, m0_stb,
      output m0_ack, m0_rdt,
      input  m1_adr, m1_dat, m1_sel, m1_we, m1_stb,
      output m1_ack, m1_rdt,
      output ram_wen, ram_waddr, ram_din, ram_raddr,
      input  ram_dout
   );

   // Environment side: requesters and RAM.
   modport master (
      output m0_adr, m0_dat, m0_sel, m0_we, m0_stb,
      input  m0_ack, m0_rdt,
      output m1_adr, m1_dat, m1_sel, m1_we, m1_stb,
      input  m1_ack, m1_rdt,
      input  ram_wen, ram_waddr, ram_din, ram_raddr,
      output ram_dout
   );
endinterface

// File: rtl/ram_byte_arbiter.sv
// Round-robin arbiter sharing a byte-wide dual-port RAM between two 32-bit word requesters.
// Each word access is split into four little-endian byte accesses; read bytes are assembled into rdt.
module ram_byte_arbiter #(
   parameter int unsigned aw = 10
) (
   input  logic            clk,
   input  logic            reset,
   ram_byte_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, XFER, RTAIL, ACK} state_t;

   state_t        state;
   logic [1:0]    cnt;
   logic          gnt;
   logic          last;
   logic [aw-3:0] adr;
   logic [31:0]   dat;
   logic [3:0]    sel;
   logic          we;
   logic [31:0]   rdt;
   logic          ack0;
   logic          ack1;
   logic          wen;
   logic [aw-1:0] waddr;
   logic [aw-1:0] raddr;
   logic [7:0]    din;

   logic          any_c;
   logic          pick_c;
   logic [aw-3:0] req_adr_c;
   logic [31:0]   req_dat_c;
   logic [3:0]    req_sel_c;
   logic          req_we_c;
   logic [1:0]    cnt_nxt_c;

   // Grant choice: alternate on a tie, otherwise whoever is requesting.
   always_comb begin
      any_c     = bus.m0_stb | bus.m1_stb;
      pick_c    = 1'b0;
      if (bus.m0_stb && bus.m1_stb)
         pick_c = ~last;
      else
         pick_c = bus.m1_stb;
      req_adr_c = pick_c ? bus.m1_adr : bus.m0_adr;
      req_dat_c = pick_c ? bus.m1_dat : bus.m0_dat;
      req_sel_c = pick_c ? bus.m1_sel : bus.m0_sel;
      req_we_c  = pick_c ? bus.m1_we  : bus.m0_we;
      cnt_nxt_c = cnt + 2'd1;
   end

   // Transaction sequencer; RAM controls are registered one cycle ahead of the byte they serve.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 2'd0;
         gnt   <= 1'b0;
         last  <= 1'b1;
         adr   <= '0;
         dat   <= 32'd0;
         sel   <= 4'd0;
         we    <= 1'b0;
         rdt   <= 32'd0;
         ack0  <= 1'b0;
         ack1  <= 1'b0;
         wen   <= 1'b0;
         waddr <= '0;
         raddr <= '0;
         din   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (any_c) begin
                  gnt   <= pick_c;
                  last  <= pick_c;
                  adr   <= req_adr_c;
                  dat   <= req_dat_c;
                  sel   <= req_sel_c;
                  we    <= req_we_c;
                  cnt   <= 2'd0;
                  waddr <= {req_adr_c, 2'd0};
                  raddr <= {req_adr_c, 2'd0};
                  din   <= req_dat_c[7:0];
                  wen   <= req_we_c & req_sel_c[0];
                  state <= XFER;
               end
            end
            XFER: begin
               if (!we) begin
                  case (cnt)
                     2'd1:    rdt[7:0]   <= bus.ram_dout;
                     2'd2:    rdt[15:8]  <= bus.ram_dout;
                     2'd3:    rdt[23:16] <= bus.ram_dout;
                     default: ;
                  endcase
               end
               if (cnt == 2'd3) begin
                  wen <= 1'b0;
                  if (we) begin
                     ack0  <= ~gnt;
                     ack1  <= gnt;
                     state <= ACK;
                  end else begin
                     state <= RTAIL;
                  end
               end else begin
                  cnt   <= cnt_nxt_c;
                  waddr <= {adr, cnt_nxt_c};
                  raddr <= {adr, cnt_nxt_c};
                  din   <= dat[{cnt_nxt_c, 3'b000} +: 8];
                  wen   <= we & sel[cnt_nxt_c];
               end
            end
            RTAIL: begin
               rdt[31:24] <= bus.ram_dout;
               ack0       <= ~gnt;
               ack1       <= gnt;
               state      <= ACK;
            end
            ACK: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.m0_ack    = ack0;
   assign bus.m1_ack    = ack1;
   assign bus.m0_rdt    = rdt;
   assign bus.m1_rdt    = rdt;
   assign bus.ram_wen   = wen;
   assign bus.ram_waddr = waddr;
   assign bus.ram_raddr = raddr;
   assign bus.ram_din   = din;

endmodule
